// File: rtl/ecat_datagram_parser_pkg.sv
// Shared constants and types for the EtherCAT datagram walker.
// Holds the command codes, the header/WKC byte counts and the parser state encoding.
package ecat_pkg;

    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_APRD = 8'h01;
    localparam logic [7:0] CMD_APWR = 8'h02;
    localparam logic [7:0] CMD_APRW = 8'h03;
    localparam logic [7:0] CMD_FPRD = 8'h04;
    localparam logic [7:0] CMD_FPWR = 8'h05;
    localparam logic [7:0] CMD_FPRW = 8'h06;
    localparam logic [7:0] CMD_BRD  = 8'h07;
    localparam logic [7:0] CMD_BWR  = 8'h08;
    localparam logic [7:0] CMD_BRW  = 8'h09;
    localparam logic [7:0] CMD_LRD  = 8'h0A;
    localparam logic [7:0] CMD_LWR  = 8'h0B;
    localparam logic [7:0] CMD_LRW  = 8'h0C;
    localparam logic [7:0] CMD_ARMW = 8'h0D;
    localparam logic [7:0] CMD_FRMW = 8'h0E;

    localparam int unsigned HDR_BYTES      = 10;
    localparam int unsigned HDR_KEEP_BYTES = 8;   // cmd..len; IRQ bytes are never stored
    localparam int unsigned WKC_BYTES      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WKC,
        ST_TAIL
    } state_t;

    function automatic logic is_logical_cmd(input logic [7:0] cmd);
        return (cmd == CMD_LRD) || (cmd == CMD_LWR) || (cmd == CMD_LRW);
    endfunction

endpackage

// File: rtl/ecat_datagram_parser_if.sv
// Byte-stream input and parsed-header outputs of the datagram parser.
// The stream source drives through master; the parser attaches through slave.
interface ecat_datagram_parser_if #(
    parameter int SUB_LEN_W = 8,
    parameter int OFS_W     = 11
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_sof;
    logic                 rx_eof;
    logic [7:0]           sub_cmd;
    logic [7:0]           sub_idx;
    logic [31:0]          sub_address;
    logic [SUB_LEN_W-1:0] sub_len;
    logic                 sub_len_sat;
    logic                 sub_more;
    logic                 subdv;
    logic                 hdr_done;
    logic                 data_valid;
    logic [OFS_W-1:0]     data_offset;
    logic                 wkc_valid;
    logic                 frame_err;

    modport master (
        output rx_data, rx_valid, rx_sof, rx_eof,
        input  sub_cmd, sub_idx, sub_address, sub_len, sub_len_sat, sub_more,
        input  subdv, hdr_done, data_valid, data_offset, wkc_valid, frame_err
    );

    modport slave (
        input  rx_data, rx_valid, rx_sof, rx_eof,
        output sub_cmd, sub_idx, sub_address, sub_len, sub_len_sat, sub_more,
        output subdv, hdr_done, data_valid, data_offset, wkc_valid, frame_err
    );
endinterface

// File: rtl/ecat_datagram_parser.sv
// Walks an EtherCAT datagram chain byte by byte, latching each header and
// tagging data/WKC bytes; logical commands raise subdv for the FMMU mapper.
module ecat_datagram_parser
    import ecat_pkg::*;
#(
    parameter int SUB_LEN_W = 8,
    parameter int OFS_W     = 11
) (
    input logic                   clk,
    input logic                   rst,
    ecat_datagram_parser_if.slave bus
);

    localparam int unsigned SUB_MAX = (1 << SUB_LEN_W) - 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OFS_W-1:0]     r_cnt;
    logic [OFS_W-1:0]     w_cnt_nxt;
    logic [63:0]          r_hdr_sr;
    logic [10:0]          r_dlen;
    logic [7:0]           r_sub_cmd;
    logic [7:0]           r_sub_idx;
    logic [31:0]          r_sub_address;
    logic [SUB_LEN_W-1:0] r_sub_len;
    logic                 r_sub_len_sat;
    logic                 r_sub_more;
    logic                 r_subdv;
    logic                 r_hdr_done;
    logic                 r_frame_err;

    logic                 w_shift;
    logic                 w_latch;
    logic                 w_err;
    logic                 w_in_data;
    logic                 w_in_wkc;
    logic [15:0]          w_len_word;
    logic [10:0]          w_len;
    logic [31:0]          w_address;
    logic                 w_len_sat;
    logic                 w_hdr_last;
    logic                 w_data_last;
    logic                 w_wkc_last;
    logic                 w_unused_len;

    // Shift register holds header bytes 0..7 with byte 0 in the top octet.
    assign w_len_word   = {r_hdr_sr[7:0], r_hdr_sr[15:8]};
    assign w_len        = w_len_word[10:0];
    assign w_address    = {r_hdr_sr[23:16], r_hdr_sr[31:24], r_hdr_sr[39:32], r_hdr_sr[47:40]};
    assign w_len_sat    = 32'(w_len) > SUB_MAX;
    assign w_unused_len = ^w_len_word[14:11];

    assign w_hdr_last  = (r_cnt == OFS_W'(HDR_BYTES - 1));
    assign w_data_last = (r_cnt == OFS_W'(r_dlen - 11'd1));
    assign w_wkc_last  = (r_cnt == OFS_W'(WKC_BYTES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_latch     = 1'b0;
        w_err       = 1'b0;
        w_in_data   = 1'b0;
        w_in_wkc    = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_sof) begin
                // sof always restarts the header walk, whatever was in progress
                w_shift     = 1'b1;
                w_cnt_nxt   = OFS_W'(1);
                w_state_nxt = ST_HDR;
                if (bus.rx_eof) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: w_state_nxt = ST_IDLE;
                    ST_HDR: begin
                        if (bus.rx_eof) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_hdr_last) begin
                            w_latch     = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = (w_len == 11'd0) ? ST_WKC : ST_DATA;
                        end else begin
                            w_shift   = (r_cnt < OFS_W'(HDR_KEEP_BYTES));
                            w_cnt_nxt = r_cnt + OFS_W'(1);
                        end
                    end
                    ST_DATA: begin
                        w_in_data = 1'b1;
                        if (bus.rx_eof) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_data_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_WKC;
                        end else begin
                            w_cnt_nxt = r_cnt + OFS_W'(1);
                        end
                    end
                    ST_WKC: begin
                        w_in_wkc = 1'b1;
                        if (!w_wkc_last) begin
                            if (bus.rx_eof) begin
                                w_err       = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_cnt_nxt = r_cnt + OFS_W'(1);
                            end
                        end else if (r_sub_more) begin
                            if (bus.rx_eof) begin
                                w_err       = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_cnt_nxt   = '0;
                                w_state_nxt = ST_HDR;
                            end
                        end else begin
                            w_state_nxt = bus.rx_eof ? ST_IDLE : ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        w_err       = !bus.rx_eof;
                        w_state_nxt = ST_IDLE;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_hdr_sr      <= '0;
            r_dlen        <= '0;
            r_sub_cmd     <= '0;
            r_sub_idx     <= '0;
            r_sub_address <= '0;
            r_sub_len     <= '0;
            r_sub_len_sat <= 1'b0;
            r_sub_more    <= 1'b0;
            r_subdv       <= 1'b0;
            r_hdr_done    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hdr_done  <= w_latch;
            r_subdv     <= w_latch & is_logical_cmd(r_hdr_sr[63:56]);
            r_frame_err <= w_err;
            if (w_shift) begin
                r_hdr_sr <= {r_hdr_sr[55:0], bus.rx_data};
            end
            if (w_latch) begin
                r_sub_cmd     <= r_hdr_sr[63:56];
                r_sub_idx     <= r_hdr_sr[55:48];
                r_sub_address <= w_address;
                r_sub_len     <= w_len_sat ? '1 : SUB_LEN_W'(w_len);
                r_sub_len_sat <= w_len_sat;
                r_sub_more    <= w_len_word[15];
                r_dlen        <= w_len;
            end
        end
    end

    assign bus.sub_cmd     = r_sub_cmd;
    assign bus.sub_idx     = r_sub_idx;
    assign bus.sub_address = r_sub_address;
    assign bus.sub_len     = r_sub_len;
    assign bus.sub_len_sat = r_sub_len_sat;
    assign bus.sub_more    = r_sub_more;
    assign bus.subdv       = r_subdv;
    assign bus.hdr_done    = r_hdr_done;
    assign bus.frame_err   = r_frame_err;
    assign bus.data_valid  = w_in_data & ~rst;
    assign bus.wkc_valid   = w_in_wkc & ~rst;
    assign bus.data_offset = (w_in_data & ~rst) ? r_cnt : '0;

endmodule
